// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the 16-bit 5-stage pipeline controller:
// opcode map, run/idle encoding, FSM states and instruction-class helpers.
package pipe_ctrl_pkg;

   localparam logic [4:0] OP_NOP   = 5'b00000;
   localparam logic [4:0] OP_HALT  = 5'b00001;
   localparam logic [4:0] OP_LOAD  = 5'b00010;
   localparam logic [4:0] OP_STORE = 5'b00011;
   localparam logic [4:0] OP_SLL   = 5'b00100;
   localparam logic [4:0] OP_SLA   = 5'b00101;
   localparam logic [4:0] OP_SRL   = 5'b00110;
   localparam logic [4:0] OP_SRA   = 5'b00111;
   localparam logic [4:0] OP_ADD   = 5'b01000;
   localparam logic [4:0] OP_ADDI  = 5'b01001;
   localparam logic [4:0] OP_SUB   = 5'b01010;
   localparam logic [4:0] OP_SUBI  = 5'b01011;
   localparam logic [4:0] OP_CMP   = 5'b01100;
   localparam logic [4:0] OP_AND   = 5'b01101;
   localparam logic [4:0] OP_OR    = 5'b01110;
   localparam logic [4:0] OP_XOR   = 5'b01111;
   localparam logic [4:0] OP_LDIH  = 5'b10000;
   localparam logic [4:0] OP_ADDC  = 5'b10001;
   localparam logic [4:0] OP_SUBC  = 5'b10010;
   localparam logic [4:0] OP_JUMP  = 5'b11000;
   localparam logic [4:0] OP_JMPR  = 5'b11001;
   localparam logic [4:0] OP_BZ    = 5'b11010;
   localparam logic [4:0] OP_BNZ   = 5'b11011;
   localparam logic [4:0] OP_BN    = 5'b11100;
   localparam logic [4:0] OP_BNN   = 5'b11101;
   localparam logic [4:0] OP_BC    = 5'b11110;
   localparam logic [4:0] OP_BNC   = 5'b11111;

   localparam logic ST_EXEC = 1'b1;
   localparam logic ST_IDLE = 1'b0;

   typedef enum logic [1:0] {
      FSM_IDLE = 2'd0,
      FSM_RUN  = 2'd1,
      FSM_HALT = 2'd2
   } fsm_e;

   // Instructions that write a register through the [10:8] field.
   function automatic logic is_writer(input logic [4:0] op);
      case (op)
         OP_LOAD, OP_LDIH, OP_ADD, OP_ADDI, OP_ADDC, OP_SUB, OP_SUBI, OP_SUBC,
         OP_AND, OP_OR, OP_XOR, OP_SLL, OP_SRL, OP_SLA, OP_SRA: is_writer = 1'b1;
         default: is_writer = 1'b0;
      endcase
   endfunction

   // Instructions that read a register through [10:8] (branch/jump base,
   // read-modify-write immediates, store data).
   function automatic logic uses_src_hi(input logic [4:0] op);
      case (op)
         OP_BZ, OP_BNZ, OP_BN, OP_BNN, OP_BC, OP_BNC, OP_JMPR,
         OP_ADDI, OP_SUBI, OP_LDIH, OP_STORE: uses_src_hi = 1'b1;
         default: uses_src_hi = 1'b0;
      endcase
   endfunction

   // Instructions that read a register through [6:4]. Immediate forms
   // (ADDI/SUBI/LDIH) carry an 8-bit constant there, so they are excluded.
   function automatic logic uses_src_mid(input logic [4:0] op);
      case (op)
         OP_LOAD, OP_STORE, OP_ADD, OP_ADDC, OP_SUB, OP_SUBC, OP_CMP,
         OP_AND, OP_OR, OP_XOR, OP_SLL, OP_SRL, OP_SLA, OP_SRA: uses_src_mid = 1'b1;
         default: uses_src_mid = 1'b0;
      endcase
   endfunction

   // Three-register ALU forms that read a second source through [2:0].
   function automatic logic uses_src_lo(input logic [4:0] op);
      case (op)
         OP_ADD, OP_ADDC, OP_SUB, OP_SUBC, OP_CMP,
         OP_AND, OP_OR, OP_XOR: uses_src_lo = 1'b1;
         default: uses_src_lo = 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/pipe_ctrl_hazard_detect.sv
// Load-use hazard detector: flags an ID instruction that reads the register
// a LOAD in EX is about to fetch, which ID forwarding cannot supply in time.
module hazard_detect
   import pipe_ctrl_pkg::*;
(
   input  logic [15:0] id_ir,
   input  logic [15:0] ex_ir,
   output logic        load_use
);

   logic [4:0] id_op;
   logic [4:0] ex_op;
   logic [2:0] ex_rd;

   assign id_op = id_ir[15:11];
   assign ex_op = ex_ir[15:11];
   assign ex_rd = ex_ir[10:8];

   // Match every source field the ID instruction actually reads against the LOAD destination.
   always_comb begin
      load_use = 1'b0;
      if (ex_op == OP_LOAD) begin
         if (uses_src_hi(id_op)  && (id_ir[10:8] == ex_rd)) load_use = 1'b1;
         if (uses_src_mid(id_op) && (id_ir[6:4]  == ex_rd)) load_use = 1'b1;
         if (uses_src_lo(id_op)  && (id_ir[2:0]  == ex_rd)) load_use = 1'b1;
      end
   end

endmodule

// File: rtl/pipe_ctrl.sv
// Central sequencer for the 5-stage pipeline: run/idle/halt control,
// load-use stall insertion, branch flush and saturating performance counters.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   FSM_IDLE | paused by host or after reset; pipeline frozen, strobes 0
//   FSM_RUN  | executing; stages advance, stalls/flushes generated
//   FSM_HALT | HALT retired in WB; frozen until start (or !enable -> IDLE)
module pipe_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int LOAD_STALL = 1,
   parameter int CNT_W      = 16
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             enable,
   input  logic             start,
   input  logic [15:0]      id_ir,
   input  logic [15:0]      ex_ir,
   input  logic [15:0]      wb_ir,
   input  logic             branch_taken,
   output logic             state,
   output logic             stall_if,
   output logic             bubble_ex,
   output logic             flush,
   output logic             halted,
   output logic [CNT_W-1:0] cycle_cnt,
   output logic [CNT_W-1:0] stall_cnt
);

   // The first bubble comes from load_use itself; the counter covers the rest.
   localparam logic [1:0] STALL_RELOAD = 2'(LOAD_STALL - 1);

   fsm_e             fsm_q,       fsm_d;
   logic [1:0]       stall_q,     stall_d;
   logic [CNT_W-1:0] cycle_q,     cycle_d;
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

   logic load_use_raw;
   logic run;
   logic load_use;
   logic stall_active;

   hazard_detect u_hazard (
      .id_ir    (id_ir),
      .ex_ir    (ex_ir),
      .load_use (load_use_raw)
   );

   assign run          = (fsm_q == FSM_RUN);
   assign load_use     = run && load_use_raw;
   assign stall_active = run && !branch_taken && (load_use || (stall_q != 2'd0));

   // Next-state selection for the run/idle/halt sequencer.
   always_comb begin
      fsm_d = fsm_q;
      case (fsm_q)
         FSM_IDLE: if (start && enable) fsm_d = FSM_RUN;
         FSM_RUN: begin
            if (!enable)                      fsm_d = FSM_IDLE;
            else if (wb_ir[15:11] == OP_HALT) fsm_d = FSM_HALT;
         end
         FSM_HALT: begin
            if (!enable)     fsm_d = FSM_IDLE;
            else if (start)  fsm_d = FSM_RUN;
         end
         default: fsm_d = FSM_IDLE;
      endcase
   end

   // Bubble down-counter: a flush discards any pending bubbles; outside RUN it holds.
   always_comb begin
      stall_d = stall_q;
      if (run) begin
         if (branch_taken)          stall_d = 2'd0;
         else if (stall_q != 2'd0)  stall_d = stall_q - 2'd1;
         else if (load_use)         stall_d = STALL_RELOAD;
      end
   end

   // Saturating performance counters.
   always_comb begin
      cycle_d     = cycle_q;
      stall_cnt_d = stall_cnt_q;
      if (run && (cycle_q != '1))              cycle_d     = cycle_q + CNT_W'(1);
      if (stall_active && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
   end

   // State registers; reset clears everything immediately.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         fsm_q       <= FSM_IDLE;
         stall_q     <= 2'd0;
         cycle_q     <= '0;
         stall_cnt_q <= '0;
      end else begin
         fsm_q       <= fsm_d;
         stall_q     <= stall_d;
         cycle_q     <= cycle_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign state     = run ? ST_EXEC : ST_IDLE;
   assign halted    = (fsm_q == FSM_HALT);
   assign stall_if  = stall_active;
   assign bubble_ex = stall_active;
   assign flush     = run && branch_taken;
   assign cycle_cnt = cycle_q;
   assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl: two instances share stimulus, one with
// LOAD_STALL=1/CNT_W=16 (a) and one with LOAD_STALL=3/CNT_W=4 (b).
module tb_pipe_ctrl;

   localparam logic [15:0] I_NOP   = 16'h0000;
   localparam logic [15:0] I_HALT  = 16'h0800;  // HALT
   localparam logic [15:0] I_LD3   = 16'h1312;  // LOAD  r3, r1, #2
   localparam logic [15:0] I_A435  = 16'h4435;  // ADD   r4, r3, r5
   localparam logic [15:0] I_A412  = 16'h4412;  // ADD   r4, r1, r2
   localparam logic [15:0] I_A312  = 16'h4312;  // ADD   r3, r1, r2
   localparam logic [15:0] I_A413  = 16'h4413;  // ADD   r4, r1, r3
   localparam logic [15:0] I_ST31  = 16'h1B10;  // STORE r3, r1, #0

   typedef struct {
      int          row;
      logic        rst, en, st;
      logic [15:0] id, ex, wb;
      logic        bt;
      logic        e_state, e_halt, e_flush, e_sa, e_sb;
      int          e_cyc_a, e_stl_a, e_cyc_b, e_stl_b;
   } vec_t;

   logic        clock = 1'b0;
   logic        reset, enable, start, branch_taken;
   logic [15:0] id_ir, ex_ir, wb_ir;

   logic        state_a, stall_if_a, bubble_ex_a, flush_a, halted_a;
   logic [15:0] cycle_cnt_a, stall_cnt_a;
   logic        state_b, stall_if_b, bubble_ex_b, flush_b, halted_b;
   logic [3:0]  cycle_cnt_b, stall_cnt_b;

   vec_t stim_q[$];
   vec_t exp_q[$];
   int   checks = 0;
   int   errors = 0;
   bit   drive_done = 1'b0;

   always #5 clock = ~clock;

   pipe_ctrl #(.LOAD_STALL(1), .CNT_W(16)) dut_a (
      .clock(clock), .reset(reset), .enable(enable), .start(start),
      .id_ir(id_ir), .ex_ir(ex_ir), .wb_ir(wb_ir), .branch_taken(branch_taken),
      .state(state_a), .stall_if(stall_if_a), .bubble_ex(bubble_ex_a), .flush(flush_a),
      .halted(halted_a), .cycle_cnt(cycle_cnt_a), .stall_cnt(stall_cnt_a)
   );

   pipe_ctrl #(.LOAD_STALL(3), .CNT_W(4)) dut_b (
      .clock(clock), .reset(reset), .enable(enable), .start(start),
      .id_ir(id_ir), .ex_ir(ex_ir), .wb_ir(wb_ir), .branch_taken(branch_taken),
      .state(state_b), .stall_if(stall_if_b), .bubble_ex(bubble_ex_b), .flush(flush_b),
      .halted(halted_b), .cycle_cnt(cycle_cnt_b), .stall_cnt(stall_cnt_b)
   );

   task automatic add(input logic rst, en, st, input logic [15:0] id, ex, wb, input logic bt,
                      input logic e_state, e_halt, e_flush, e_sa, e_sb,
                      input int cyc_a, stl_a, cyc_b, stl_b);
      vec_t v;
      v.row = stim_q.size();
      v.rst = rst; v.en = en; v.st = st; v.id = id; v.ex = ex; v.wb = wb; v.bt = bt;
      v.e_state = e_state; v.e_halt = e_halt; v.e_flush = e_flush; v.e_sa = e_sa; v.e_sb = e_sb;
      v.e_cyc_a = cyc_a; v.e_stl_a = stl_a; v.e_cyc_b = cyc_b; v.e_stl_b = stl_b;
      stim_q.push_back(v);
   endtask

   task automatic chk(input int row, input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL row %0d %s: got %0d expected %0d", row, nm, act, exp);
      end
   endtask

   // Driver: apply one vector per cycle just after the rising edge and post its expectation.
   initial begin
      vec_t v;
      reset = 1'b1; enable = 1'b0; start = 1'b0; branch_taken = 1'b0;
      id_ir = I_NOP; ex_ir = I_NOP; wb_ir = I_NOP;
      //   rst en st id      ex     wb      bt | st hl fl sa sb  cycA stlA cycB stlB
      add(1, 0, 0, I_NOP,  I_NOP, I_NOP,  0,   0, 0, 0, 0, 0,  0, 0,  0, 0);  // 0 reset
      add(0, 1, 1, I_NOP,  I_NOP, I_NOP,  0,   0, 0, 0, 0, 0,  0, 0,  0, 0);  // 1 start
      add(0, 1, 0, I_NOP,  I_NOP, I_NOP,  0,   1, 0, 0, 0, 0,  0, 0,  0, 0);
      add(0, 1, 0, I_NOP,  I_NOP, I_NOP,  0,   1, 0, 0, 0, 0,  1, 0,  1, 0);
      add(0, 1, 0, I_NOP,  I_NOP, I_NOP,  0,   1, 0, 0, 0, 0,  2, 0,  2, 0);
      add(0, 0, 0, I_NOP,  I_NOP, I_NOP,  0,   1, 0, 0, 0, 0,  3, 0,  3, 0);  // 5 drop enable
      add(0, 0, 0, I_NOP,  I_NOP, I_NOP,  0,   0, 0, 0, 0, 0,  4, 0,  4, 0);
      add(0, 0, 0, I_NOP,  I_NOP, I_NOP,  0,   0, 0, 0, 0, 0,  4, 0,  4, 0);
      add(0, 1, 1, I_NOP,  I_NOP, I_NOP,  0,   0, 0, 0, 0, 0,  4, 0,  4, 0);
      add(0, 1, 0, I_A435, I_LD3, I_NOP,  0,   1, 0, 0, 1, 1,  4, 0,  4, 0);  // 9 load-use
      add(0, 1, 0, I_A435, I_NOP, I_NOP,  0,   1, 0, 0, 0, 1,  5, 1,  5, 1);
      add(0, 1, 0, I_A435, I_NOP, I_NOP,  0,   1, 0, 0, 0, 1,  6, 1,  6, 2);
      add(0, 1, 0, I_A435, I_NOP, I_NOP,  0,   1, 0, 0, 0, 0,  7, 1,  7, 3);
      add(0, 1, 0, I_A412, I_LD3, I_NOP,  0,   1, 0, 0, 0, 0,  8, 1,  8, 3);  // 13 no match
      add(0, 1, 0, I_A312, I_LD3, I_NOP,  0,   1, 0, 0, 0, 0,  9, 1,  9, 3);  // dest only
      add(0, 1, 0, I_A435, I_A312, I_NOP, 0,   1, 0, 0, 0, 0, 10, 1, 10, 3);  // EX not LOAD
      add(0, 1, 0, I_ST31, I_LD3, I_NOP,  0,   1, 0, 0, 1, 1, 11, 1, 11, 3);  // 16 store data
      add(0, 1, 0, I_ST31, I_NOP, I_NOP,  1,   1, 0, 1, 0, 0, 12, 2, 12, 4);  // flush kills pending
      add(0, 1, 0, I_NOP,  I_NOP, I_NOP,  0,   1, 0, 0, 0, 0, 13, 2, 13, 4);
      add(0, 1, 0, I_A413, I_LD3, I_NOP,  1,   1, 0, 1, 0, 0, 14, 2, 14, 4);  // 19 load-use + branch
      add(0, 1, 0, I_NOP,  I_NOP, I_NOP,  0,   1, 0, 0, 0, 0, 15, 2, 15, 4);
      add(0, 1, 0, I_A413, I_LD3, I_NOP,  0,   1, 0, 0, 1, 1, 16, 2, 15, 4);  // 21 b saturated
      add(0, 0, 0, I_A413, I_NOP, I_NOP,  0,   1, 0, 0, 0, 1, 17, 3, 15, 5);
      add(0, 0, 0, I_A413, I_NOP, I_NOP,  0,   0, 0, 0, 0, 0, 18, 3, 15, 6);
      add(0, 1, 1, I_A413, I_NOP, I_NOP,  0,   0, 0, 0, 0, 0, 18, 3, 15, 6);
      add(0, 1, 0, I_A413, I_NOP, I_NOP,  0,   1, 0, 0, 0, 1, 18, 3, 15, 6);  // 25 resumes
      add(0, 1, 0, I_A413, I_NOP, I_NOP,  0,   1, 0, 0, 0, 0, 19, 3, 15, 7);
      add(0, 1, 0, I_NOP,  I_NOP, I_HALT, 1,   1, 0, 1, 0, 0, 20, 3, 15, 7);  // 27 HALT in WB
      add(0, 1, 0, I_A435, I_LD3, I_NOP,  0,   0, 1, 0, 0, 0, 21, 3, 15, 7);
      add(0, 1, 1, I_A435, I_LD3, I_NOP,  0,   0, 1, 0, 0, 0, 21, 3, 15, 7);
      add(0, 1, 0, I_A435, I_LD3, I_NOP,  0,   1, 0, 0, 1, 1, 21, 3, 15, 7);  // 30 run again
      add(1, 1, 0, I_A435, I_NOP, I_NOP,  0,   0, 0, 0, 0, 0,  0, 0,  0, 0);  // 31 reset mid-stall
      add(0, 1, 0, I_NOP,  I_NOP, I_NOP,  0,   0, 0, 0, 0, 0,  0, 0,  0, 0);
      add(0, 1, 1, I_NOP,  I_NOP, I_NOP,  0,   0, 0, 0, 0, 0,  0, 0,  0, 0);
      add(0, 1, 0, I_NOP,  I_NOP, I_NOP,  0,   1, 0, 0, 0, 0,  0, 0,  0, 0);
      add(0, 1, 0, I_NOP,  I_NOP, I_NOP,  0,   1, 0, 0, 0, 0,  1, 0,  1, 0);
      while (stim_q.size() > 0) begin
         v = stim_q.pop_front();
         @(posedge clock);
         #1;
         reset = v.rst; enable = v.en; start = v.st;
         id_ir = v.id; ex_ir = v.ex; wb_ir = v.wb; branch_taken = v.bt;
         exp_q.push_back(v);
      end
      @(posedge clock);
      drive_done = 1'b1;
   end

   // Monitor: sample outputs mid-cycle and compare against the oldest expectation.
   initial begin
      vec_t e;
      forever begin
         @(negedge clock);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk(e.row, "state_a",     int'(state_a),     int'(e.e_state));
            chk(e.row, "state_b",     int'(state_b),     int'(e.e_state));
            chk(e.row, "halted_a",    int'(halted_a),    int'(e.e_halt));
            chk(e.row, "halted_b",    int'(halted_b),    int'(e.e_halt));
            chk(e.row, "flush_a",     int'(flush_a),     int'(e.e_flush));
            chk(e.row, "flush_b",     int'(flush_b),     int'(e.e_flush));
            chk(e.row, "stall_if_a",  int'(stall_if_a),  int'(e.e_sa));
            chk(e.row, "bubble_ex_a", int'(bubble_ex_a), int'(e.e_sa));
            chk(e.row, "stall_if_b",  int'(stall_if_b),  int'(e.e_sb));
            chk(e.row, "bubble_ex_b", int'(bubble_ex_b), int'(e.e_sb));
            chk(e.row, "cycle_cnt_a", int'(cycle_cnt_a), e.e_cyc_a);
            chk(e.row, "stall_cnt_a", int'(stall_cnt_a), e.e_stl_a);
            chk(e.row, "cycle_cnt_b", int'(cycle_cnt_b), e.e_cyc_b);
            chk(e.row, "stall_cnt_b", int'(stall_cnt_b), e.e_stl_b);
         end
      end
   end

   // Finish once all expectations are consumed; bounded so a stuck run still reports.
   initial begin
      int waited;
      waited = 0;
      while (!(drive_done && exp_q.size() == 0) && waited < 2000) begin
         @(posedge clock);
         waited++;
      end
      if (waited >= 2000) begin
         errors++;
         $display("FAIL completion: got timeout after %0d cycles expected scoreboard drained", waited);
      end
      if (checks < 12) begin
         errors++;
         $display("FAIL check_count: got %0d expected at least 12", checks);
      end
      repeat (2) @(posedge clock);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
